// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared CPU datapath widths and opcode encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int CPU_DATA_W   = 8;
  localparam int CPU_NUM_REGS = 8;
  localparam int CPU_REG_AW   = 3;

  typedef enum logic [1:0] {
    FUNC_MOV = 2'b00,
    FUNC_ADD = 2'b01,
    FUNC_SUB = 2'b10,
    FUNC_LDI = 2'b11
  } func_e;

endpackage

`default_nettype wire

// File: rtl/regfile_8x8.sv
// ============================================================================
// regfile_8x8 : 2 async read ports, 1 sync write port, reset loads R[i]=i
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_8x8
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int NUM_REGS = CPU_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CPU_REG_AW-1:0] raddr_a,
  input  logic [CPU_REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a,
  output logic [DATA_W-1:0]     rdata_b,
  input  logic                  we,
  input  logic [CPU_REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Reset wins over a coincident write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
    end else if (we) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign rdata_a = r_regs[raddr_a];
  assign rdata_b = r_regs[raddr_b];

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// id_stage : decode operand fetch with WB bypass and ID/EX pipeline register.
// Macro ID_EX_FWD_EN enables the EX-stage forward path (highest priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int NUM_REGS = CPU_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            func,
  input  logic [CPU_REG_AW-1:0] rdst,
  input  logic [CPU_REG_AW-1:0] rsrc,
  input  logic                  status,
  input  logic                  stall,
  input  logic                  wb_en,
  input  logic [CPU_REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_fwd_en,
  input  logic [CPU_REG_AW-1:0] ex_fwd_addr,
  input  logic [DATA_W-1:0]     ex_fwd_data,
  output logic                  ex_valid,
  output logic [1:0]            ex_func,
  output logic [CPU_REG_AW-1:0] ex_rdst,
  output logic [DATA_W-1:0]     ex_a,
  output logic [DATA_W-1:0]     ex_b
);

  logic [DATA_W-1:0]     w_rf_a;
  logic [DATA_W-1:0]     w_rf_b;
  logic [DATA_W-1:0]     w_op_a;
  logic [DATA_W-1:0]     w_op_b;
  logic                  w_fwd_hit_a;
  logic                  w_fwd_hit_b;

  logic                  r_ex_valid;
  logic [1:0]            r_ex_func;
  logic [CPU_REG_AW-1:0] r_ex_rdst;
  logic [DATA_W-1:0]     r_ex_a;
  logic [DATA_W-1:0]     r_ex_b;

  regfile_8x8 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rdst),
    .raddr_b (rsrc),
    .rdata_a (w_rf_a),
    .rdata_b (w_rf_b),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

`ifdef ID_EX_FWD_EN
  assign w_fwd_hit_a = ex_fwd_en && (ex_fwd_addr == rdst);
  assign w_fwd_hit_b = ex_fwd_en && (ex_fwd_addr == rsrc);
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ex_fwd_en, ex_fwd_addr, ex_fwd_data};
  assign w_fwd_hit_a  = 1'b0;
  assign w_fwd_hit_b  = 1'b0;
`endif

  // Operand resolution: EX forward > WB bypass > register file
  always_comb begin
    w_op_a = w_rf_a;
    w_op_b = w_rf_b;
    if (wb_en && (wb_addr == rdst)) w_op_a = wb_data;
    if (wb_en && (wb_addr == rsrc)) w_op_b = wb_data;
`ifdef ID_EX_FWD_EN
    if (w_fwd_hit_a) w_op_a = ex_fwd_data;
    if (w_fwd_hit_b) w_op_b = ex_fwd_data;
`endif
    if (func == FUNC_LDI) w_op_b = DATA_W'(rsrc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_func  <= 2'b00;
      r_ex_rdst  <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
    end else if (!stall) begin
      if (status) begin
        r_ex_valid <= 1'b1;
        r_ex_func  <= func;
        r_ex_rdst  <= rdst;
        r_ex_a     <= w_op_a;
        r_ex_b     <= w_op_b;
      end else begin
        r_ex_valid <= 1'b0;
        r_ex_func  <= 2'b00;
        r_ex_rdst  <= '0;
        r_ex_a     <= '0;
        r_ex_b     <= '0;
      end
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_func  = r_ex_func;
  assign ex_rdst  = r_ex_rdst;
  assign ex_a     = r_ex_a;
  assign ex_b     = r_ex_b;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// ============================================================================
// tb_id_stage : directed scenarios plus randomized run against a reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] func;
  logic [2:0] rdst, rsrc;
  logic       status, stall;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       ex_fwd_en;
  logic [2:0] ex_fwd_addr;
  logic [7:0] ex_fwd_data;
  logic       ex_valid;
  logic [1:0] ex_func;
  logic [2:0] ex_rdst;
  logic [7:0] ex_a, ex_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk         (clk),
    .reset       (reset),
    .func        (func),
    .rdst        (rdst),
    .rsrc        (rsrc),
    .status      (status),
    .stall       (stall),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_fwd_en   (ex_fwd_en),
    .ex_fwd_addr (ex_fwd_addr),
    .ex_fwd_data (ex_fwd_data),
    .ex_valid    (ex_valid),
    .ex_func     (ex_func),
    .ex_rdst     (ex_rdst),
    .ex_a        (ex_a),
    .ex_b        (ex_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register array plus expected ID/EX fields
  logic [7:0] m_regs [8];
  logic       m_ok = 1'b0;
  logic       e_valid;
  logic [1:0] e_func;
  logic [2:0] e_rdst;
  logic [7:0] e_a, e_b;

  function automatic logic [7:0] operand(input logic [2:0] addr);
`ifdef ID_EX_FWD_EN
    if (ex_fwd_en && ex_fwd_addr == addr) return ex_fwd_data;
`endif
    if (wb_en && wb_addr == addr) return wb_data;
    return m_regs[addr];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'(i);
      {e_valid, e_func, e_rdst, e_a, e_b} = '0;
      m_ok = 1'b1;
    end else begin
      if (!stall) begin
        if (status) begin
          e_valid = 1'b1;
          e_func  = func;
          e_rdst  = rdst;
          e_a     = operand(rdst);
          e_b     = (func == 2'b11) ? {5'b0, rsrc} : operand(rsrc);
        end else begin
          {e_valid, e_func, e_rdst, e_a, e_b} = '0;
        end
      end
      if (wb_en) m_regs[wb_addr] = wb_data;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_valid", 32'(ex_valid), 32'(e_valid));
      check("model_func",  32'(ex_func),  32'(e_func));
      check("model_rdst",  32'(ex_rdst),  32'(e_rdst));
      check("model_a",     32'(ex_a),     32'(e_a));
      check("model_b",     32'(ex_b),     32'(e_b));
    end
  end

  task automatic drive(input logic st, input logic [1:0] f, input logic [2:0] rd,
                       input logic [2:0] rs, input logic stl, input logic we,
                       input logic [2:0] wa, input logic [7:0] wd, input logic fe,
                       input logic [2:0] fa, input logic [7:0] fd);
    status = st; func = f; rdst = rd; rsrc = rs; stall = stl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    ex_fwd_en = fe; ex_fwd_addr = fa; ex_fwd_data = fd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    check("reset_valid", 32'(ex_valid), 32'd0);
    check("reset_a",     32'(ex_a),     32'd0);
    reset = 1'b0;

    drive(1, 2'b01, 2, 5, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_func",  32'(ex_func),  32'h1);
    check("add_rdst",  32'(ex_rdst),  32'h2);
    check("add_a",     32'(ex_a),     32'h02);
    check("add_b",     32'(ex_b),     32'h05);

    drive(0, 2'b00, 0, 0, 0, 1, 6, 8'h77, 0, 0, 8'h00);
    step();
    check("bubble_valid", 32'(ex_valid), 32'd0);
    check("bubble_b",     32'(ex_b),     32'd0);
    drive(1, 2'b11, 3, 6, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    check("ldi_a", 32'(ex_a), 32'h03);
    check("ldi_b", 32'(ex_b), 32'h06);

    drive(1, 2'b00, 0, 4, 0, 1, 4, 8'hA5, 0, 0, 8'h00);
    step();
    check("wb_bypass_b", 32'(ex_b), 32'hA5);
    drive(1, 2'b00, 4, 4, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    check("wb_written_a", 32'(ex_a), 32'hA5);
    check("wb_written_b", 32'(ex_b), 32'hA5);

    drive(1, 2'b10, 1, 4, 0, 1, 4, 8'hA5, 1, 4, 8'h3C);
    step();
    check("fwd_a", 32'(ex_a), 32'h01);
`ifdef ID_EX_FWD_EN
    check("fwd_b", 32'(ex_b), 32'h3C);
`else
    check("fwd_b", 32'(ex_b), 32'hA5);
`endif

    drive(1, 2'b01, 2, 5, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'(c), 2'(c + 1), 3'(c), 3'(7 - c), 1, c == 0, 2, 8'h5A, 0, 0, 8'h00);
      step();
      check("stall_valid", 32'(ex_valid), 32'd1);
      check("stall_func",  32'(ex_func),  32'h1);
      check("stall_rdst",  32'(ex_rdst),  32'h2);
      check("stall_a",     32'(ex_a),     32'h02);
      check("stall_b",     32'(ex_b),     32'h05);
    end
    drive(1, 2'b00, 2, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    check("stall_wb_seen", 32'(ex_a), 32'h5A);

    reset = 1'b1;
    drive(1, 2'b01, 1, 1, 1, 1, 1, 8'hFF, 0, 0, 8'h00);
    step();
    check("rst_prio_valid", 32'(ex_valid), 32'd0);
    reset = 1'b0;
    drive(1, 2'b00, 1, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    step();
    check("rst_prio_r1_a", 32'(ex_a), 32'h01);
    check("rst_prio_r1_b", 32'(ex_b), 32'h01);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), 3'($urandom),
            $urandom_range(0, 3) == 0, 1'($urandom), 3'($urandom), 8'($urandom),
            1'($urandom), 3'($urandom), 8'($urandom));
      step();
    end
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register/operand data width.
REQ-002 SHALL have parameter NUM_REGS, default 8, register file depth (3-bit addressing).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port func  input  2  opcode field from IF/ID register.
REQ-006 SHALL have ports rdst, rsrc  input  3 each  destination and source register fields from IF/ID.
REQ-007 SHALL have port status  input  1  IF/ID entry valid.
REQ-008 SHALL have port stall  input  1  hold ID/EX register contents.
REQ-009 SHALL have ports wb_en (1), wb_addr (3), wb_data (DATA_W)  input  writeback port.
REQ-010 SHALL have ports ex_fwd_en (1), ex_fwd_addr (3), ex_fwd_data (DATA_W)  input  result of the instruction currently in EX.
REQ-011 SHALL have outputs ex_valid (1), ex_func (2), ex_rdst (3), ex_a (DATA_W), ex_b (DATA_W)  registered ID/EX fields.

Function
REQ-012 SHALL read operand A from R[rdst] and operand B from R[rsrc] combinationally and register them into ex_a/ex_b, one-cycle latency from status to ex_valid.
REQ-013 SHALL, for func=2'b11 (LDI), set ex_b to {5'b0, rsrc} instead of R[rsrc].
REQ-014 SHALL resolve each operand by priority: EX forward (ex_fwd_en and address match) > WB bypass (wb_en and address match) > register file.
REQ-015 SHALL write wb_data into R[wb_addr] on the clock edge when wb_en=1; all registers writable, including R0.
REQ-016 SHALL, when stall=1, hold all ex_* outputs unchanged; register file writes still occur.
REQ-017 SHALL, when stall=0 and status=0, load a bubble: ex_valid=0, ex_func/ex_rdst/ex_a/ex_b=0.
REQ-018 SHALL, when stall=0 and status=1, load ex_valid=1, ex_func=func, ex_rdst=rdst and the resolved operands.
REQ-019 SHALL, when both operands address the same register, deliver identical forwarded values to ex_a and ex_b.

Reset
REQ-020 SHALL, when reset=1 at a rising edge, set R[i]=i (R0=8'h00 ... R7=8'h07) and all ex_* outputs to 0.
REQ-021 SHALL give reset priority over stall, wb_en and status in the same cycle; no write occurs.

Configuration
REQ-022 SHALL, with ID_EX_FWD_EN defined, implement the EX forward path of REQ-014.
REQ-023 SHALL, without ID_EX_FWD_EN, retain ex_fwd_* ports but ignore them; priority reduces to WB bypass > register file.

Structure
REQ-024 SHALL take DATA_W default, NUM_REGS, and opcode constants FUNC_MOV=2'b00, FUNC_ADD=2'b01, FUNC_SUB=2'b10, FUNC_LDI=2'b11 from shared package cpu_pkg.
REQ-025 SHALL instantiate one sub-module regfile_8x8 (two combinational read ports, one synchronous write port, synchronous reset to R[i]=i); bypass/forward muxing and ID/EX register stay in id_stage.

Verification
REQ-026 SHALL cover reset then status=1, func=01, rdst=2, rsrc=5 -> next cycle ex_valid=1, ex_func=01, ex_rdst=2, ex_a=8'h02, ex_b=8'h05.
REQ-027 SHALL cover func=11, rdst=3, rsrc=6 -> ex_b=8'h06 regardless of R6 contents, ex_a=R3.
REQ-028 SHALL cover wb_en=1, wb_addr=4, wb_data=8'hA5 same cycle as read of rsrc=4 -> ex_b=8'hA5; following read of R4 also returns 8'hA5.
REQ-029 SHALL cover (macro defined) ex_fwd_en=1 addr=4 data=8'h3C and wb_en=1 addr=4 data=8'hA5 -> ex_b=8'h3C; macro undefined -> ex_b=8'hA5.
REQ-030 SHALL cover stall=1 for 3 cycles with changing inputs -> ex_* constant; wb write during stall visible after release.
REQ-031 SHALL cover reset asserted with stall=1 and wb_en=1 addr=1 data=8'hFF -> ex_valid=0, R1=8'h01.
